// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch PC owner and redirect arbiter.
// Drives imem handshake plus IF/ID and ID/EX flush/stall.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jal_ID,
    input  logic        jalr_ID,
    input  logic [31:0] jal_target_ID,
    input  logic [31:0] jalr_target_ID,
    input  logic        B_JUMP_EX,
    input  logic [31:0] br_target_EX,
    input  logic        load_use_stall,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_IF,
    output logic        if_valid,
    output logic        stall_IF,
    output logic        flush_IFID,
    output logic        flush_IDEX
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] pend_pc;
    logic [31:0] pend_nxt;
    logic [31:0] target;
    logic        active;
    logic        br_take;
    logic        jmp_take;
    logic        redirect;

    // Redirect arbitration: the older instruction (EX) wins.
    always_comb begin
        active   = (state != BOOT);
        br_take  = active & B_JUMP_EX;
        jmp_take = active & (jal_ID | jalr_ID) & ~load_use_stall;
        redirect = br_take | jmp_take;
        target   = jal_target_ID;
        priority case (1'b1)
            B_JUMP_EX: target = br_target_EX;
            jalr_ID:   target = jalr_target_ID;
            default:   target = jal_target_ID;
        endcase
    end

    // Handshake, flush and stall outputs.
    always_comb begin
        imem_req   = active;
        imem_addr  = pc_IF;
        stall_IF   = active & ((load_use_stall & ~B_JUMP_EX)
                     | ((state == FETCH) & ~imem_ready));
        flush_IFID = redirect;
        flush_IDEX = active & (B_JUMP_EX | load_use_stall);
        if_valid   = (state == FETCH) & imem_ready
                     & ~redirect & ~stall_IF;
    end

    // Next PC / pending target / state.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_IF;
        pend_nxt  = pend_pc;
        unique case (state)
            BOOT: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    if (imem_ready) begin
                        pc_nxt = target;
                    end else begin
                        pend_nxt  = target;
                        state_nxt = DRAIN;
                    end
                end else if (imem_ready && !stall_IF) begin
                    pc_nxt = pc_IF + 32'd4;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pend_nxt = target;
                end
                if (imem_ready) begin
                    pc_nxt    = redirect ? target : pend_pc;
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // State registers; reset abandons any outstanding fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BOOT;
            pc_IF   <= RESET_PC;
            pend_pc <= RESET_PC;
        end else begin
            state   <= state_nxt;
            pc_IF   <= pc_nxt;
            pend_pc <= pend_nxt;
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed scenarios plus randomized
// traffic checked against a behavioural fetch model.
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jal_ID = 1'b0;
    logic        jalr_ID = 1'b0;
    logic [31:0] jal_target_ID = '0;
    logic [31:0] jalr_target_ID = '0;
    logic        B_JUMP_EX = 1'b0;
    logic [31:0] br_target_EX = '0;
    logic        load_use_stall = 1'b0;
    logic        imem_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_IF;
    logic        if_valid;
    logic        stall_IF;
    logic        flush_IFID;
    logic        flush_IDEX;

    int errors = 0;
    int checks = 0;

    pc_redirect_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .jal_ID         (jal_ID),
        .jalr_ID        (jalr_ID),
        .jal_target_ID  (jal_target_ID),
        .jalr_target_ID (jalr_target_ID),
        .B_JUMP_EX      (B_JUMP_EX),
        .br_target_EX   (br_target_EX),
        .load_use_stall (load_use_stall),
        .imem_ready     (imem_ready),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .pc_IF          (pc_IF),
        .if_valid       (if_valid),
        .stall_IF       (stall_IF),
        .flush_IFID     (flush_IFID),
        .flush_IDEX     (flush_IDEX)
    );

    always #5 clk = ~clk;

    // Model: started = past the boot cycle; waiting = a
    // redirect is parked until memory answers.
    bit          m_started;
    bit          m_waiting;
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    bit          e_req, e_valid, e_stall, e_fifd, e_fidex;
    bit          e_redir;
    logic [31:0] e_tgt;

    task automatic model_reset();
        m_started = 0;
        m_waiting = 0;
        m_pc      = 32'h0;
        m_pend    = 32'h0;
    endtask

    task automatic model_eval();
        bit br, jx;
        br      = m_started && B_JUMP_EX;
        jx      = m_started && (jal_ID || jalr_ID) && !load_use_stall;
        e_redir = br || jx;
        if (B_JUMP_EX)    e_tgt = br_target_EX;
        else if (jalr_ID) e_tgt = jalr_target_ID;
        else              e_tgt = jal_target_ID;
        e_req   = m_started;
        e_stall = m_started && ((load_use_stall && !B_JUMP_EX)
                  || (!m_waiting && !imem_ready));
        e_fifd  = e_redir;
        e_fidex = m_started && (B_JUMP_EX || load_use_stall);
        e_valid = m_started && !m_waiting && imem_ready
                  && !e_redir && !e_stall;
    endtask

    task automatic model_step();
        model_eval();
        if (!m_started) begin
            m_started = 1;
        end else if (m_waiting) begin
            if (imem_ready) begin
                m_pc      = e_redir ? e_tgt : m_pend;
                m_waiting = 0;
            end else if (e_redir) begin
                m_pend = e_tgt;
            end
        end else if (e_redir) begin
            if (imem_ready) m_pc = e_tgt;
            else begin
                m_pend    = e_tgt;
                m_waiting = 1;
            end
        end else if (imem_ready && !e_stall) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        jal_ID = 0; jalr_ID = 0; B_JUMP_EX = 0;
        load_use_stall = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        imem_ready = 1;
        @(negedge clk);
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (pc_IF !== 32'h0 || imem_req !== 1'b0 || if_valid !== 1'b0
            || stall_IF !== 1'b0 || flush_IFID !== 1'b0
            || flush_IDEX !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%h req=%b v=%b st=%b fi=%b fe=%b want 0",
                     pc_IF, imem_req, if_valid, stall_IF, flush_IFID, flush_IDEX);
        end
        tick();
        rst_n = 1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL boot_req: got %b want 0", imem_req);
        end
        tick();
    endtask

    task automatic test_seq_and_jal();
        imem_ready = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (imem_addr !== 32'(4 * i) || if_valid !== 1'b1
                || imem_req !== 1'b1 || flush_IFID !== 1'b0
                || flush_IDEX !== 1'b0) begin
                errors++;
                $display("FAIL seq_fetch%0d: addr=%h v=%b req=%b fi=%b fe=%b",
                         i, imem_addr, if_valid, imem_req, flush_IFID, flush_IDEX);
            end
            tick();
        end
        jal_ID = 1; jal_target_ID = 32'h100;
        #1;
        checks++;
        if (imem_addr !== 32'h8 || flush_IFID !== 1'b1
            || flush_IDEX !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL jal_redirect: addr=%h fi=%b fe=%b v=%b want 8 1 0 0",
                     imem_addr, flush_IFID, flush_IDEX, if_valid);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (imem_addr !== 32'h100 || if_valid !== 1'b1) begin
            errors++;
            $display("FAIL jal_target: addr=%h v=%b want 100 1", imem_addr, if_valid);
        end
    endtask

    task automatic test_branch_vs_jalr();
        B_JUMP_EX = 1; br_target_EX = 32'h200;
        jalr_ID = 1; jalr_target_ID = 32'h300;
        #1;
        checks++;
        if (flush_IFID !== 1'b1 || flush_IDEX !== 1'b1 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL br_jalr_flush: fi=%b fe=%b v=%b want 1 1 0",
                     flush_IFID, flush_IDEX, if_valid);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL br_priority: addr=%h want 200", imem_addr);
        end
    endtask

    task automatic test_load_use();
        load_use_stall = 1; jal_ID = 1; jal_target_ID = 32'h400;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (stall_IF !== 1'b1 || flush_IDEX !== 1'b1 || flush_IFID !== 1'b0
                || if_valid !== 1'b0 || pc_IF !== 32'h200) begin
                errors++;
                $display("FAIL load_use%0d: st=%b fe=%b fi=%b v=%b pc=%h",
                         i, stall_IF, flush_IDEX, flush_IFID, if_valid, pc_IF);
            end
            tick();
        end
        load_use_stall = 0;
        #1;
        checks++;
        if (flush_IFID !== 1'b1 || flush_IDEX !== 1'b0 || stall_IF !== 1'b0) begin
            errors++;
            $display("FAIL lu_release: fi=%b fe=%b st=%b want 1 0 0",
                     flush_IFID, flush_IDEX, stall_IF);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (imem_addr !== 32'h400) begin
            errors++;
            $display("FAIL lu_jal_target: addr=%h want 400", imem_addr);
        end
    endtask

    task automatic test_drain();
        jal_ID = 1; jal_target_ID = 32'h10;
        tick();
        clear_inputs();
        imem_ready = 0;
        B_JUMP_EX = 1; br_target_EX = 32'h80;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (imem_addr !== 32'h10 || if_valid !== 1'b0 || imem_req !== 1'b1) begin
                errors++;
                $display("FAIL drain_hold%0d: addr=%h v=%b req=%b want 10 0 1",
                         i, imem_addr, if_valid, imem_req);
            end
            tick();
            B_JUMP_EX = 0;
            if (i == 2) imem_ready = 1;
        end
        #1;
        checks++;
        if (imem_addr !== 32'h80 || if_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain_target: addr=%h v=%b want 80 1", imem_addr, if_valid);
        end
    endtask

    task automatic test_reset_in_drain();
        imem_ready = 0;
        jal_ID = 1; jal_target_ID = 32'h500;
        tick();
        clear_inputs();
        #1;
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (pc_IF !== 32'h0 || imem_req !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_reset: pc=%h req=%b v=%b want 0 0 0",
                     pc_IF, imem_req, if_valid);
        end
        tick();
        rst_n = 1;
        imem_ready = 1;
        tick();
        #1;
        checks++;
        if (imem_addr !== 32'h0 || imem_req !== 1'b1 || if_valid !== 1'b1) begin
            errors++;
            $display("FAIL refetch: addr=%h req=%b v=%b want 0 1 1",
                     imem_addr, imem_req, if_valid);
        end
    endtask

    task automatic test_wrap();
        imem_ready = 1;
        jal_ID = 1; jal_target_ID = 32'hFFFF_FFF8;
        tick();
        clear_inputs();
        tick();
        #1;
        checks++;
        if (pc_IF !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_pre: pc=%h want fffffffc", pc_IF);
        end
        tick();
        #1;
        checks++;
        if (pc_IF !== 32'h0 || if_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap: pc=%h v=%b want 0 1", pc_IF, if_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            imem_ready     = ($urandom_range(0, 3) != 0);
            B_JUMP_EX      = ($urandom_range(0, 7) == 0);
            jal_ID         = ($urandom_range(0, 5) == 0);
            jalr_ID        = ($urandom_range(0, 5) == 0);
            load_use_stall = ($urandom_range(0, 4) == 0);
            br_target_EX   = $urandom & 32'hFFFF_FFFC;
            jal_target_ID  = $urandom & 32'hFFFF_FFFC;
            jalr_target_ID = $urandom & 32'hFFFF_FFFC;
            #1;
            model_eval();
            checks++;
            if (pc_IF !== m_pc || imem_addr !== m_pc || imem_req !== e_req
                || if_valid !== e_valid || stall_IF !== e_stall
                || flush_IFID !== e_fifd || flush_IDEX !== e_fidex) begin
                errors++;
                $display("FAIL rand%0d: pc=%h/%h req=%b/%b v=%b/%b st=%b/%b fi=%b/%b fe=%b/%b (got/want)",
                         i, pc_IF, m_pc, imem_req, e_req, if_valid, e_valid,
                         stall_IF, e_stall, flush_IFID, e_fifd, flush_IDEX, e_fidex);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_seq_and_jal();
        test_branch_vs_jalr();
        test_load_use();
        test_drain();
        test_reset_in_drain();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Fetch-side program-counter controller for the 5-stage RV32I pipeline. Owns the PC register, arbitrates the next-PC source between sequential fetch, jal/jalr resolved in ID and taken branches resolved in EX, and sequences a ready/request handshake to instruction memory. It also generates the IF/ID and ID/EX flush and stall controls that accompany every redirect or load-use hazard.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- jal_ID  in  1  jal decoded in ID
- jalr_ID  in  1  jalr decoded in ID
- jal_target_ID  in  32  jal target, valid with jal_ID
- jalr_target_ID  in  32  jalr target (LSB already cleared), valid with jalr_ID
- B_JUMP_EX  in  1  branch in EX resolved taken
- br_target_EX  in  32  branch target, valid with B_JUMP_EX
- load_use_stall  in  1  hazard unit: load-use dependency in ID
- imem_ready  in  1  instruction memory returns data for imem_addr this cycle
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, equals pc_IF
- pc_IF  out  32  current PC register
- if_valid  out  1  fetched word in this cycle is to be latched into IF/ID
- stall_IF  out  1  hold PC and IF/ID
- flush_IFID  out  1  clear IF/ID next edge
- flush_IDEX  out  1  insert bubble into ID/EX next edge

## Operation
- Redirect priority: B_JUMP_EX > jalr_ID > jal_ID (older instruction wins). redirect = B_JUMP_EX | ((jal_ID|jalr_ID) & ~load_use_stall).
- jal/jalr in ID are ignored while load_use_stall=1 (operand not yet valid); branch in EX is never suppressed.
- Flushes: B_JUMP_EX -> flush_IFID=1, flush_IDEX=1. jal/jalr redirect -> flush_IFID=1 only. load_use_stall without branch -> flush_IDEX=1, stall_IF=1, flush_IFID=0.
- States: BOOT, FETCH, DRAIN.
  - BOOT: reset state; imem_req=0. Next cycle -> FETCH.
  - FETCH: imem_req=1, imem_addr=pc_IF. If redirect: pc_IF <= target; if imem_ready=0 and redirect, save target in pend_pc and -> DRAIN (pc_IF held so address stays stable). If no redirect, imem_ready=1 and stall_IF=0: pc_IF <= pc_IF+4 (mod 2^32).
  - DRAIN: imem_req=1, address unchanged, if_valid=0. On imem_ready: pc_IF <= pend_pc, -> FETCH. A newer redirect in DRAIN overwrites pend_pc (same priority rule).
- if_valid = (state==FETCH) & imem_ready & ~redirect & ~stall_IF.
- stall_IF also asserted in FETCH when imem_ready=0 (PC and IF/ID held). Flush outputs take precedence over stall in the IF/ID register.
- Redirect with imem_ready=1 in FETCH: returned word discarded, pc_IF <= target, stays in FETCH.

## Timing
- Reset (async, any time, including mid-DRAIN): pc_IF=RESET_PC, state=BOOT, pend_pc=RESET_PC, imem_req=0, if_valid=0, stall_IF=0, flush_IFID=0, flush_IDEX=0. Outstanding fetch is abandoned.
- First request: cycle 1 after rst_n deasserts, address RESET_PC.
- Zero-wait memory: one instruction per cycle, pc_IF advances every edge.
- Redirect penalty: jal/jalr 1 bubble, taken branch 2 bubbles; new target presented on imem_addr the cycle after the redirect (or the cycle after imem_ready in DRAIN).
- All flush/stall outputs are combinational from current inputs and state; PC and state update on rising clk.
- pc_IF+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.

## Test plan
- Reset release, imem_ready tied 1 -> imem_addr 0x0,0x4,0x8 on cycles 1,2,3; if_valid=1 each; no flushes.
- jal_ID=1 target 0x100 at PC 0x8, ready=1 -> flush_IFID=1, flush_IDEX=0, if_valid=0 that cycle, next imem_addr=0x100.
- Same cycle B_JUMP_EX (0x200) and jalr_ID (0x300) -> both flushes=1, next imem_addr=0x200.
- load_use_stall=1 with jal_ID=1 (0x400) -> stall_IF=1, flush_IDEX=1, flush_IFID=0, pc_IF unchanged; jal taken the cycle stall drops.
- imem_ready=0 for 3 cycles at 0x10, B_JUMP_EX to 0x80 in first -> imem_addr held 0x10, if_valid=0 throughout, after ready imem_addr=0x80.
- rst_n asserted while in DRAIN -> immediately pc_IF=RESET_PC, imem_req=0; refetch from RESET_PC cycle 1 after release; PC wrap from 0xFFFFFFFC -> 0x0.
